// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ valid/ready
// producers, holding each grant for a burst of up to MAX_BURST beats.
module fifo_wr_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_BURST  = 4,
   parameter int unsigned ID_WIDTH   = 2,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_write_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   input  logic                          fifo_full,
   output logic                          grant_valid,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic [CNT_WIDTH-1:0]          beat_count,
   output logic [CNT_WIDTH-1:0]          stall_count
);

   localparam int unsigned BurstW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BurstW-1:0] BurstLast = BurstW'(MAX_BURST - 1);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e                state_q, state_d;
   logic                  grant_valid_q, grant_valid_d;
   logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
   logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
   logic [BurstW-1:0]     burst_cnt_q, burst_cnt_d;
   logic [CNT_WIDTH-1:0]  beat_count_q, beat_count_d;
   logic [CNT_WIDTH-1:0]  stall_count_q, stall_count_d;

   logic                  sel_valid;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  found_hi, found_lo;
   logic [ID_WIDTH-1:0]   win_hi, win_lo, winner;

   // Granted producer's valid/data; only the granted slice is ever looked at.
   always_comb begin
      sel_valid = 1'b0;
      sel_data  = req_data[DATA_WIDTH-1:0];
      for (int i = 0; i < NUM_REQ; i++) begin
         if (state_q == StBurst && grant_id_q == ID_WIDTH'(i)) begin
            sel_valid = req_valid[i];
            sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Round-robin: lowest valid index above last_grant, else lowest valid index overall.
   // Equivalent to a wrapping search from last_grant+1 without any modulo arithmetic.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      win_hi   = '0;
      win_lo   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i]) begin
            if (!found_lo) begin
               found_lo = 1'b1;
               win_lo   = ID_WIDTH'(i);
            end
            if (!found_hi && ID_WIDTH'(i) > last_grant_q) begin
               found_hi = 1'b1;
               win_hi   = ID_WIDTH'(i);
            end
         end
      end
      winner = found_hi ? win_hi : win_lo;
   end

   always_comb begin
      state_d       = state_q;
      grant_valid_d = grant_valid_q;
      grant_id_d    = grant_id_q;
      last_grant_d  = last_grant_q;
      burst_cnt_d   = burst_cnt_q;
      beat_count_d  = beat_count_q;
      stall_count_d = stall_count_q;
      unique case (state_q)
         StIdle: begin
            if (|req_valid) begin
               grant_id_d    = winner;
               grant_valid_d = 1'b1;
               burst_cnt_d   = '0;
               state_d       = StBurst;
            end
         end
         StBurst: begin
            if (!sel_valid) begin
               last_grant_d  = grant_id_q;
               grant_valid_d = 1'b0;
               burst_cnt_d   = '0;
               state_d       = StIdle;
            end else if (fifo_full) begin
               if (stall_count_q != '1) stall_count_d = stall_count_q + CNT_WIDTH'(1);
            end else begin
               beat_count_d = beat_count_q + CNT_WIDTH'(1);
               if (burst_cnt_q == BurstLast) begin
                  last_grant_d  = grant_id_q;
                  grant_valid_d = 1'b0;
                  burst_cnt_d   = '0;
                  state_d       = StIdle;
               end else begin
                  burst_cnt_d = burst_cnt_q + BurstW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
         last_grant_q  <= ID_WIDTH'(NUM_REQ - 1);
         burst_cnt_q   <= '0;
         beat_count_q  <= '0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         grant_valid_q <= grant_valid_d;
         grant_id_q    <= grant_id_d;
         last_grant_q  <= last_grant_d;
         burst_cnt_q   <= burst_cnt_d;
         beat_count_q  <= beat_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   // Gated by reset so a beat pending when reset hits is never written or consumed.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = (state_q == StBurst) && (grant_id_q == ID_WIDTH'(i)) && !fifo_full
                        && !reset;
      end
   end

   assign fifo_write_en = (state_q == StBurst) && sel_valid && !fifo_full && !reset;
   assign fifo_data_in  = sel_data;
   assign grant_valid   = grant_valid_q;
   assign grant_id      = grant_id_q;
   assign beat_count    = beat_count_q;
   assign stall_count   = stall_count_q;

endmodule
